// File: rtl/ram_dump_tx.sv
// rtl/ram_dump_tx.sv - streams RAM[0..LAST_ADDR] out as 8N1 UART frames on a button edge
// Optional trailing checksum frame: define RAM_DUMP_CHECKSUM_EN.
module ram_dump_tx #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [3:0] LAST_ADDR    = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dump_btn,
  output logic [3:0] ram_rd_addr,
  input  logic [7:0] ram_rd_data,
  output logic       uart_tx,
  output logic       busy,
  output logic [3:0] cur_addr,
  output logic       done
);

  localparam logic [11:0] BAUD_MAX = 12'(CLKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT, DONE
`ifdef RAM_DUMP_CHECKSUM_EN
    , CSUM_LOAD
`endif
  } state_t;

  state_t      state;
  logic [3:0]  addr;
  logic [7:0]  shreg;
  logic [11:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic        btn_prev;
  logic        baud_end;
`ifdef RAM_DUMP_CHECKSUM_EN
  logic [7:0]  csum;
  logic        csum_phase;
`endif

  // Address register feeds the RAM directly so data is ready by the end of FETCH.
  assign ram_rd_addr = addr;
  assign baud_end    = (baud_cnt == BAUD_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      addr     <= 4'd0;
      shreg    <= 8'd0;
      baud_cnt <= 12'd0;
      bit_cnt  <= 3'd0;
      btn_prev <= 1'b1;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      cur_addr <= 4'd0;
      done     <= 1'b0;
`ifdef RAM_DUMP_CHECKSUM_EN
      csum       <= 8'd0;
      csum_phase <= 1'b0;
`endif
    end else begin
      btn_prev <= dump_btn;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (!start && dump_btn && !btn_prev) begin
            addr  <= 4'd0;
            busy  <= 1'b1;
            state <= FETCH;
`ifdef RAM_DUMP_CHECKSUM_EN
            csum       <= 8'd0;
            csum_phase <= 1'b0;
`endif
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          shreg    <= ram_rd_data;
          cur_addr <= addr;
          uart_tx  <= 1'b0;
          baud_cnt <= 12'd0;
          state    <= START_BIT;
`ifdef RAM_DUMP_CHECKSUM_EN
          csum <= csum + ram_rd_data;
`endif
        end
        START_BIT: begin
          if (baud_end) begin
            baud_cnt <= 12'd0;
            uart_tx  <= shreg[0];
            state    <= DATA_BITS;
          end else begin
            baud_cnt <= baud_cnt + 12'd1;
          end
        end
        DATA_BITS: begin
          if (baud_end) begin
            baud_cnt <= 12'd0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= 3'd0;
              uart_tx <= 1'b1;
              state   <= STOP_BIT;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              uart_tx <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 12'd1;
          end
        end
        STOP_BIT: begin
          if (baud_end) begin
            baud_cnt <= 12'd0;
            state    <= NEXT;
          end else begin
            baud_cnt <= baud_cnt + 12'd1;
          end
        end
        NEXT: begin
`ifdef RAM_DUMP_CHECKSUM_EN
          if (csum_phase)
            state <= DONE;
          else if (addr == LAST_ADDR)
            state <= CSUM_LOAD;
`else
          if (addr == LAST_ADDR)
            state <= DONE;
`endif
          else begin
            addr  <= addr + 4'd1;
            state <= FETCH;
          end
        end
`ifdef RAM_DUMP_CHECKSUM_EN
        CSUM_LOAD: begin
          shreg      <= csum;
          csum_phase <= 1'b1;
          uart_tx    <= 1'b0;
          baud_cnt   <= 12'd0;
          state      <= START_BIT;
        end
`endif
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          uart_tx <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dump_tx.sv
// tb/tb_ram_dump_tx.sv - directed self-checking bench for ram_dump_tx
// Expects 17 frames in the checksum step when built with RAM_DUMP_CHECKSUM_EN.
module tb_ram_dump_tx;
  localparam int CPB = 4;
`ifdef RAM_DUMP_CHECKSUM_EN
  localparam int EXP_FRAMES = 17;
`else
  localparam int EXP_FRAMES = 16;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       dump_btn = 1'b1;
  logic [3:0] ram_rd_addr;
  logic [7:0] ram_rd_data = 8'd0;
  logic       uart_tx;
  logic       busy;
  logic [3:0] cur_addr;
  logic       done;
  logic [7:0] ram [16];

  int errors = 0;
  int checks = 0;
  int ncyc = 0;
  int done_cnt = 0;

  ram_dump_tx #(.CLKS_PER_BIT(CPB), .LAST_ADDR(4'hF)) dut (
    .clk(clk), .reset(reset), .start(start), .dump_btn(dump_btn),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .uart_tx(uart_tx), .busy(busy), .cur_addr(cur_addr), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ram_rd_data <= ram[ram_rd_addr];
  always @(posedge clk) ncyc <= ncyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fall(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_busy_low(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Samples every bit at its centre, starting from the first cycle seen low.
  task automatic recv_byte(input int max, output logic [7:0] b, output logic stop,
                           output int t_fall, output bit ok);
    b = 8'h00;
    stop = 1'b0;
    wait_fall(max, ok);
    t_fall = ncyc;
    if (ok) begin
      repeat (2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        b[k] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      stop = uart_tx;
    end
  endtask

  task automatic pulse(output int t_acc);
    @(negedge clk) dump_btn = 1'b1;
    @(negedge clk) t_acc = ncyc;
    dump_btn = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    int         t_acc, t_fall, t_prev, d0, nfr, nbad;
    bit         ok, flag;

    for (int i = 0; i < 16; i++) ram[i] = 8'(i * 16 + 1);

    // Reset with the button held high throughout.
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", int'(uart_tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cur_addr", int'(cur_addr), 0);
    chk("rst_rd_addr", int'(ram_rd_addr), 0);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("held_btn_no_dump", int'(busy), 0);
    dump_btn = 1'b0;
    repeat (2) @(negedge clk);

    // Full dump: data, frame timing, address tracking.
    d0 = done_cnt;
    pulse(t_acc);
    chk("busy_on_accept", int'(busy), 1);
    t_prev = 0;
    for (int i = 0; i < 16; i++) begin
      recv_byte(200, b, stop, t_fall, ok);
      chk($sformatf("frame_seen_%0d", i), int'(ok), 1);
      chk($sformatf("data_%0d", i), int'(b), (i * 16 + 1) & 8'hFF);
      chk($sformatf("stop_%0d", i), int'(stop), 1);
      if (i == 0) chk("first_fall_lat", t_fall - t_acc, 2);
      else        chk($sformatf("gap_%0d", i), t_fall - t_prev, 10 * CPB + 3);
      t_prev = t_fall;
    end
    wait_busy_low(100, ok);
    chk("busy_low_after_dump", int'(ok), 1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("idle_tx_high", int'(uart_tx), 1);

    // start high: request discarded and not queued.
    start = 1'b1;
    pulse(t_acc);
    flag = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || uart_tx !== 1'b1) flag = 1'b0;
    end
    chk("start_blocks_dump", int'(flag), 1);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_queued_dump", int'(busy), 0);

    // Long hold plus a mid-dump toggle yields exactly one dump.
    d0 = done_cnt;
    nfr = 0;
    nbad = 0;
    @(negedge clk) dump_btn = 1'b1;
    fork
      begin
        repeat (500) @(negedge clk);
        dump_btn = 1'b0;
        repeat (3) @(negedge clk);
        dump_btn = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b1;
        dump_btn = 1'b0;
      end
      begin
        for (int i = 0; i < 16; i++) begin
          recv_byte(200, b, stop, t_fall, ok);
          if (ok) nfr++;
          if (b !== 8'(i * 16 + 1)) nbad++;
        end
      end
    join
    start = 1'b0;
    wait_busy_low(100, ok);
    chk("hold_busy_low", int'(ok), 1);
    wait_fall(300, ok);
    chk("hold_no_extra_frame", int'(ok), 0);
    chk("hold_frames", nfr, 16);
    chk("hold_data_bad", nbad, 0);
    chk("hold_done_once", done_cnt - d0, 1);

    // Reset in data bit 3 of byte 5 (0x51, bit 3 = 0).
    pulse(t_acc);
    for (int i = 0; i < 5; i++) recv_byte(200, b, stop, t_fall, ok);
    wait_fall(200, ok);
    chk("byte5_start", int'(ok), 1);
    repeat (17) @(negedge clk);
    chk("byte5_bit3", int'(uart_tx), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_uart_tx", int'(uart_tx), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_cur_addr", int'(cur_addr), 0);
    reset = 1'b1;
    wait_fall(300, ok);
    chk("midrst_no_resume", int'(ok), 0);
    chk("midrst_idle", int'(busy), 0);

    // Constant RAM: checksum frame (if built in) is 16*0x10 mod 256 = 0x00.
    for (int i = 0; i < 16; i++) ram[i] = 8'h10;
    pulse(t_acc);
    nfr = 0;
    nbad = 0;
    for (int i = 0; i < 18; i++) begin
      recv_byte(200, b, stop, t_fall, ok);
      if (!ok) break;
      nfr++;
      if (i < 16 && b !== 8'h10) nbad++;
      if (i == 16) chk("csum_value", int'(b), 0);
    end
    chk("csum_frame_count", nfr, EXP_FRAMES);
    chk("csum_data_bad", nbad, 0);
    chk("csum_busy_low", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
